// File: rtl/display_pkg.sv
// Shared display definitions: code constants, glyph table, scan state.
// Used by seven_seg_scanner and seg_glyph_decoder.
package display_pkg;

    localparam logic [5:0] CODE_BLANK = 6'h3F;
    localparam logic [5:0] CODE_ALARM = 6'h0A;
    localparam logic [5:0] CODE_DASH  = 6'h10;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [7:0] DIG_OFF = 8'hFF;

    // Active-high gfedcba; codes 0x11..0x1F pad to blank.
    localparam logic [6:0] GLYPH_TABLE [32] = '{
        0:  7'h3F,
        1:  7'h06,
        2:  7'h5B,
        3:  7'h4F,
        4:  7'h66,
        5:  7'h6D,
        6:  7'h7D,
        7:  7'h07,
        8:  7'h7F,
        9:  7'h6F,
        10: 7'h77,
        11: 7'h7C,
        12: 7'h39,
        13: 7'h5E,
        14: 7'h79,
        15: 7'h71,
        16: 7'h40,
        default: 7'h00
    };

    typedef enum logic {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } scan_state_t;

    function automatic logic [7:0] digit_sel_n(input logic [2:0] idx);
        return ~(8'b1 << idx);
    endfunction

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Display path bundle: code bus in, digit/segment pins and frame_sync out.
// master = scanner side, slave = producer/observer side.
interface seven_seg_scanner_if;

    logic [7:0][5:0] display_code;
    logic [7:0]      digit_n;
    logic [7:0]      seg_n;
    logic            frame_sync;

    modport master (
        input  display_code,
        output digit_n,
        output seg_n,
        output frame_sync
    );

    modport slave (
        output display_code,
        input  digit_n,
        input  seg_n,
        input  frame_sync
    );

endinterface

// File: rtl/seg_glyph_decoder.sv
// 6-bit display code to active-low {dp,g,f,e,d,c,b,a}.
// Codes above 0x10 (including CODE_BLANK) give all segments off.
module seg_glyph_decoder
    import display_pkg::*;
(
    input  logic [5:0] code,
    output logic [7:0] seg_n
);

    // Table lookup for the defined range, blank otherwise; dp never lit.
    always_comb begin
        seg_n = SEG_OFF;
        unique case (1'b1)
            (code <= CODE_DASH): seg_n = {1'b1, ~GLYPH_TABLE[code[4:0]]};
            default:             seg_n = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Eight-digit common-anode scanner with frame-coherent snapshot.
// Optional ghost blanking at slot start: define SEG_GHOST_BLANK_EN.
module seven_seg_scanner
    import display_pkg::*;
#(
    parameter int SCAN_DIV     = 12500,
    parameter int BLANK_CYCLES = 64
) (
    input  logic                clock,
    input  logic                reset_n,
    seven_seg_scanner_if.master bus
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

    if (BLANK_CYCLES < 1 || BLANK_CYCLES >= SCAN_DIV) begin : g_bad_cfg
        $error("BLANK_CYCLES must be in 1..SCAN_DIV-1");
    end

    logic [CW-1:0]   cnt_q;
    logic [2:0]      idx_q;
    logic [2:0]      idx_d;
    logic [7:0][5:0] snap_q;
    logic [7:0][5:0] snap_d;
    logic            tick;
    logic            wrap;
    logic [7:0]      seg_dec;
    logic [7:0]      digit_drv;
    logic [7:0]      digit_q;
    logic [7:0]      seg_q;
    logic            sync_q;

    assign tick   = (cnt_q == CNT_LAST);
    assign wrap   = tick && (idx_q == 3'd7);
    assign idx_d  = tick ? idx_q + 3'd1 : idx_q;
    assign snap_d = wrap ? bus.display_code : snap_q;

    // Outputs are built from next-state idx/snapshot so the pins
    // change on the same edge as idx and frame_sync.
    assign digit_drv = digit_sel_n(idx_d);

    seg_glyph_decoder u_dec (
        .code  (snap_d[idx_d]),
        .seg_n (seg_dec)
    );

    // Slot counter: 0..SCAN_DIV-1, wrapping.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Digit index, frame snapshot and frame_sync pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idx_q  <= 3'd7;
            snap_q <= {8{CODE_BLANK}};
            sync_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            snap_q <= snap_d;
            sync_q <= wrap;
        end
    end

`ifdef SEG_GHOST_BLANK_EN
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    scan_state_t state_q;

    // SHOW/BLANK FSM with registered pins; every slot opens blank.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BLANK;
            digit_q <= DIG_OFF;
            seg_q   <= SEG_OFF;
        end else begin
            unique case (state_q)
                SHOW: begin
                    if (tick) begin
                        state_q <= BLANK;
                        digit_q <= DIG_OFF;
                        seg_q   <= SEG_OFF;
                    end else begin
                        digit_q <= digit_drv;
                        seg_q   <= seg_dec;
                    end
                end
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_q <= SHOW;
                        digit_q <= digit_drv;
                        seg_q   <= seg_dec;
                    end else begin
                        digit_q <= DIG_OFF;
                        seg_q   <= SEG_OFF;
                    end
                end
                default: begin
                    state_q <= BLANK;
                    digit_q <= DIG_OFF;
                    seg_q   <= SEG_OFF;
                end
            endcase
        end
    end
`else
    // Always showing: drive the selected digit for the whole slot.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            digit_q <= DIG_OFF;
            seg_q   <= SEG_OFF;
        end else begin
            digit_q <= digit_drv;
            seg_q   <= seg_dec;
        end
    end
`endif

    assign bus.digit_n    = digit_q;
    assign bus.seg_n      = seg_q;
    assign bus.frame_sync = sync_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner (SCAN_DIV=16, BLANK_CYCLES=4).
// Frame table plus hand sequences for reset and lead-in.
module tb_seven_seg_scanner;

    localparam int SD = 16;
    localparam int BC = 4;

    logic clock;
    logic reset_n;
    int   n_cmp;
    int   n_err;

    seven_seg_scanner_if bus ();

    seven_seg_scanner #(
        .SCAN_DIV     (SD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0][5:0] code_start;
        logic [7:0][5:0] code_mid;
        logic [7:0][7:0] exp_seg;
    } frame_t;

    frame_t tbl [5];

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Checks one 16-cycle slot, starting at its first cycle.
    task automatic check_slot(input int k, input logic [7:0] exp_seg);
        logic [7:0] ed;
        logic [7:0] es;
        logic [7:0] ef;
        for (int c = 0; c < SD; c++) begin
            ed = ~(8'b1 << k);
            es = exp_seg;
`ifdef SEG_GHOST_BLANK_EN
            if (c < BC) begin
                ed = 8'hFF;
                es = 8'hFF;
            end
`endif
            ef = {7'b0, (k == 0 && c == 0)};
            chk($sformatf("digit_n s%0d c%0d", k, c), bus.digit_n, ed);
            chk($sformatf("seg_n s%0d c%0d", k, c), bus.seg_n, es);
            chk($sformatf("frame_sync s%0d c%0d", k, c),
                {7'b0, bus.frame_sync}, ef);
            @(negedge clock);
        end
    endtask

    task automatic wait_sync(input int budget, output int n);
        n = 0;
        while (!bus.frame_sync && n < budget) begin
            @(negedge clock);
            n++;
        end
        n_cmp++;
        if (!bus.frame_sync) begin
            n_err++;
            $display("FAIL sync_timeout: got 0 want 1 after %0d cycles", n);
        end
    endtask

    logic [7:0][5:0] code_a;
    logic [7:0][5:0] code_b;
    logic [7:0][5:0] code_c;
    logic [7:0][5:0] code_d;
    logic [7:0][5:0] code_blank;
    logic [7:0][7:0] seg_off;
    int              n;

    initial begin
        n_cmp = 0;
        n_err = 0;

        code_blank = {8{6'h3F}};
        seg_off    = {8{8'hFF}};
        code_a = {6'h3F, 6'h3F, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h09};
        code_b = {6'h0A, 6'h3F, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h00};
        code_c = {6'h10, 6'h3F, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h00};
        code_d = {6'h2A, 6'h3F, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h00};

        tbl[0] = '{code_a, code_a, seg_off};
        tbl[1] = '{code_a, code_b,
            {8'hFF, 8'hFF, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h90}};
        tbl[2] = '{code_b, code_c,
            {8'h88, 8'hFF, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'hC0}};
        tbl[3] = '{code_c, code_d,
            {8'hBF, 8'hFF, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'hC0}};
        tbl[4] = '{code_d, code_d,
            {8'hFF, 8'hFF, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'hC0}};

        reset_n = 1'b0;
        bus.display_code = code_blank;
        repeat (3) @(negedge clock);
        chk("reset digit_n", bus.digit_n, 8'hFF);
        chk("reset seg_n", bus.seg_n, 8'hFF);
        chk("reset frame_sync", {7'b0, bus.frame_sync}, 8'h00);

        reset_n = 1'b1;
        wait_sync(4 * SD, n);
        chk("lead-in length", 8'(n), 8'(SD));

        for (int f = 0; f < 5; f++) begin
            bus.display_code = tbl[f].code_start;
            for (int k = 0; k < 8; k++) begin
                if (k == 3) bus.display_code = tbl[f].code_mid;
                check_slot(k, tbl[f].exp_seg[k]);
            end
        end

        repeat (4 * SD + 5) @(negedge clock);
        chk("pre-reset digit_n", bus.digit_n, 8'hEF);
        chk("pre-reset seg_n", bus.seg_n, 8'hA4);
        reset_n = 1'b0;
        #1;
        chk("async reset digit_n", bus.digit_n, 8'hFF);
        chk("async reset seg_n", bus.seg_n, 8'hFF);
        chk("async reset frame_sync", {7'b0, bus.frame_sync}, 8'h00);
        bus.display_code = code_blank;
        @(negedge clock);
        chk("held reset digit_n", bus.digit_n, 8'hFF);
        reset_n = 1'b1;
        wait_sync(4 * SD, n);
        chk("restart lead-in length", 8'(n), 8'(SD));
        check_slot(0, 8'hFF);
        check_slot(1, 8'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
